// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    RELEASE,
    WAIT_ACK,
    DELAY,
    DONE,
    FAULT
  } seq_state_e;

  // The counter only ever holds a loaded value minus one, so clog2 of the largest count suffices.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Sequencer-to-domain bundle: warm-reset request, per-stage acks in; stage resets and status out.
interface rst_seq_ctrl_if
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES = 4
);
  localparam int KW = idx_width(NUM_STAGES);

  logic                  sw_reset_req;
  logic [NUM_STAGES-1:0] stage_ack;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  seq_done;
  logic                  seq_fault;
  logic [KW-1:0]         fault_stage;

  modport master (
    input  sw_reset_req, stage_ack,
    output stage_rst_n, seq_done, seq_fault, fault_stage
  );

  modport slave (
    output sw_reset_req, stage_ack,
    input  stage_rst_n, seq_done, seq_fault, fault_stage
  );
endinterface

// File: rtl/rst_seq_timer.sv
// Loadable down-counter shared by the hold, settle and ack-watchdog phases.
// Latency: load/decrement take effect on the next edge; zero is a decode of the register.
// Backpressure: none; the controller always loads before it decrements.
module rst_seq_timer #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Releases NUM_STAGES reset domains in order, each waiting for its ack; RST_SEQ_TIMEOUT_EN adds the ack watchdog/FAULT.
// Latency: stage k+1 releases STAGE_DLY+1 edges after ack k is sampled; all outputs registered.
// Backpressure: stage_ack is a level handshake; sw_reset_req outranks any same-cycle ack or timeout.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYC    = 8,
  parameter int STAGE_DLY   = 4,
  parameter int ACK_TIMEOUT = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  rst_seq_ctrl_if.master  bus
);

  localparam int CW = cnt_width(HOLD_CYC, STAGE_DLY, ACK_TIMEOUT);
  localparam int KW = idx_width(NUM_STAGES);

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] DLY_LD  = CW'(STAGE_DLY - 1);
`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] ACK_LD  = CW'(ACK_TIMEOUT - 1);
`endif
  localparam logic [KW-1:0] LAST_K  = KW'(NUM_STAGES - 1);

  seq_state_e            state, state_nxt;
  logic [KW-1:0]         k;
  logic                  t_load, t_dec, t_zero;
  logic [CW-1:0]         t_val;
  logic                  sw_hit, ack_k, last_k, fault_hit;
  logic [NUM_STAGES-1:0] rst_q;
  logic                  done_q;

  // A warm request while already holding would restart the hold count, so HOLD ignores it.
  assign sw_hit = bus.sw_reset_req && (state != HOLD);
  assign ack_k  = bus.stage_ack[k];
  assign last_k = (k == LAST_K);

  rst_seq_timer #(
    .W       (CW),
    .RST_VAL (HOLD_LD)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  always_comb begin
    state_nxt = state;
    t_load    = 1'b0;
    t_val     = HOLD_LD;
    t_dec     = 1'b0;
    if (sw_hit) begin
      state_nxt = HOLD;
      t_load    = 1'b1;
      t_val     = HOLD_LD;
    end else begin
      case (state)
        HOLD: begin
          if (t_zero) state_nxt = RELEASE;
          else        t_dec     = 1'b1;
        end
        RELEASE: begin
          state_nxt = WAIT_ACK;
`ifdef RST_SEQ_TIMEOUT_EN
          t_load    = 1'b1;
          t_val     = ACK_LD;
`endif
        end
        WAIT_ACK: begin
          if (ack_k) begin
            if (last_k) begin
              state_nxt = DONE;
            end else begin
              state_nxt = DELAY;
              t_load    = 1'b1;
              t_val     = DLY_LD;
            end
          end
`ifdef RST_SEQ_TIMEOUT_EN
          else if (t_zero) state_nxt = FAULT;
          else             t_dec     = 1'b1;
`endif
        end
        DELAY: begin
          if (t_zero) state_nxt = RELEASE;
          else        t_dec     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fault_hit = (state == WAIT_ACK) && (state_nxt == FAULT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= HOLD;
      k      <= '0;
      rst_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (sw_hit) begin
        k      <= '0;
        rst_q  <= '0;
        done_q <= 1'b0;
      end else if (fault_hit) begin
        rst_q  <= '0;
      end else begin
        case (state)
          RELEASE: rst_q[k] <= 1'b1;
          DELAY:   if (t_zero) k <= k + 1'b1;
          DONE:    done_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bus.stage_rst_n = rst_q;
  assign bus.seq_done    = done_q;

`ifdef RST_SEQ_TIMEOUT_EN
  logic          fault_q;
  logic [KW-1:0] fstage_q;

  // fault_stage survives a warm reset so software can read which domain hung.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_q  <= 1'b0;
      fstage_q <= '0;
    end else if (sw_hit) begin
      fault_q  <= 1'b0;
    end else if (fault_hit) begin
      fault_q  <= 1'b1;
      fstage_q <= k;
    end
  end

  assign bus.seq_fault   = fault_q;
  assign bus.fault_stage = fstage_q;
`else
  assign bus.seq_fault   = 1'b0;
  assign bus.fault_stage = '0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl; edge numbers are counted from the first edge after reset release.
module tb_rst_seq_ctrl;

  localparam int NS = 4;
  localparam int HC = 8;
  localparam int SD = 4;
  localparam int AT = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  rst_seq_ctrl_if #(.NUM_STAGES(NS)) bus ();

  rst_seq_ctrl #(
    .NUM_STAGES  (NS),
    .HOLD_CYC    (HC),
    .STAGE_DLY   (SD),
    .ACK_TIMEOUT (AT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int edge_n  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic release_rst(input logic [NS-1:0] ack);
    reset_n = 1'b0;
    bus.sw_reset_req = 1'b0;
    bus.stage_ack = ack;
    tick();
    tick();
    reset_n = 1'b1;
    edge_n = -1;
  endtask

  // Returns the edge number at which stage_rst_n[b] is first seen high, or -1 on timeout.
  task automatic wait_bit(input int b, output int e);
    bit seen;
    e = -1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (bus.stage_rst_n[b]) begin
        e = edge_n;
        seen = 1'b1;
      end
    end
  endtask

  // Acks each stage so that the ack is sampled two edges after its reset rises.
  task automatic bring_up(input int n);
    int e;
    for (int s = 0; s < n; s++) begin
      wait_bit(s, e);
      tick();
      bus.stage_ack[s] = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.sw_reset_req = 1'b0;
    bus.stage_ack = '0;
    tick();
    tick();
    vectors++;
    if (bus.stage_rst_n !== 4'b0000) begin
      errors++; $display("FAIL reset_rst_n: got %b expected 0000", bus.stage_rst_n);
    end
    vectors++;
    if (bus.seq_done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b expected 0", bus.seq_done);
    end
    vectors++;
    if (bus.seq_fault !== 1'b0) begin
      errors++; $display("FAIL reset_fault: got %b expected 0", bus.seq_fault);
    end
    vectors++;
    if (bus.fault_stage !== 2'd0) begin
      errors++; $display("FAIL reset_fault_stage: got %0d expected 0", bus.fault_stage);
    end
  endtask

  task automatic test_cold();
    int e;
    int exp_e[4] = '{8, 15, 22, 29};
    logic [3:0] exp_m[4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    release_rst(4'b0000);
    for (int s = 0; s < NS; s++) begin
      wait_bit(s, e);
      vectors++;
      if (e !== exp_e[s]) begin
        errors++; $display("FAIL cold_edge_%0d: got edge %0d expected %0d", s, e, exp_e[s]);
      end
      vectors++;
      if (bus.stage_rst_n !== exp_m[s]) begin
        errors++; $display("FAIL cold_mask_%0d: got %b expected %b", s, bus.stage_rst_n, exp_m[s]);
      end
      tick();
      bus.stage_ack[s] = 1'b1;
    end
    tick();
    vectors++;
    if (bus.seq_done !== 1'b0) begin
      errors++; $display("FAIL cold_done_early: got %b expected 0 at edge %0d", bus.seq_done, edge_n);
    end
    tick();
    vectors++;
    if (bus.seq_done !== 1'b1) begin
      errors++; $display("FAIL cold_done: got %b expected 1 at edge %0d", bus.seq_done, edge_n);
    end
    tick();
    vectors++;
    if (bus.stage_rst_n !== 4'b1111) begin
      errors++; $display("FAIL cold_hold_done: got %b expected 1111", bus.stage_rst_n);
    end
  endtask

  // Runs from DONE left by the cold sequence.
  task automatic test_warm();
    int e;
    int exp_e[4] = '{8, 15, 22, 29};
    bus.stage_ack = '0;
    bus.sw_reset_req = 1'b1;
    tick();
    bus.sw_reset_req = 1'b0;
    edge_n = -1;
    vectors++;
    if (bus.stage_rst_n !== 4'b0000) begin
      errors++; $display("FAIL warm_rst_n: got %b expected 0000", bus.stage_rst_n);
    end
    vectors++;
    if (bus.seq_done !== 1'b0) begin
      errors++; $display("FAIL warm_done: got %b expected 0", bus.seq_done);
    end
    repeat (4) tick();
    bus.sw_reset_req = 1'b1;
    tick();
    bus.sw_reset_req = 1'b0;
    for (int s = 0; s < NS; s++) begin
      wait_bit(s, e);
      vectors++;
      if (e !== exp_e[s]) begin
        errors++; $display("FAIL warm_edge_%0d: got edge %0d expected %0d", s, e, exp_e[s]);
      end
      tick();
      bus.stage_ack[s] = 1'b1;
    end
    tick();
    tick();
    vectors++;
    if (bus.seq_done !== 1'b1) begin
      errors++; $display("FAIL warm_done_again: got %b expected 1 at edge %0d", bus.seq_done, edge_n);
    end
  endtask

  task automatic test_early_acks();
    int e;
    logic [3:0] exp_m[4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    release_rst(4'b1111);
    for (int s = 0; s < NS; s++) begin
      wait_bit(s, e);
      vectors++;
      if (e !== 8 + 6 * s) begin
        errors++; $display("FAIL early_edge_%0d: got edge %0d expected %0d", s, e, 8 + 6 * s);
      end
      vectors++;
      if (bus.stage_rst_n !== exp_m[s]) begin
        errors++; $display("FAIL early_mask_%0d: got %b expected %b", s, bus.stage_rst_n, exp_m[s]);
      end
    end
    tick();
    vectors++;
    if (bus.seq_done !== 1'b0) begin
      errors++; $display("FAIL early_done_early: got %b expected 0 at edge %0d", bus.seq_done, edge_n);
    end
    tick();
    vectors++;
    if (bus.seq_done !== 1'b1) begin
      errors++; $display("FAIL early_done: got %b expected 1 at edge %0d", bus.seq_done, edge_n);
    end
  endtask

  task automatic test_mid_reset();
    int e;
    release_rst(4'b0000);
    bring_up(1);
    wait_bit(1, e);
    tick();
    bus.stage_ack[1] = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.stage_rst_n !== 4'b0011) begin
      errors++; $display("FAIL mid_before: got %b expected 0011", bus.stage_rst_n);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.stage_rst_n !== 4'b0000) begin
      errors++; $display("FAIL mid_async: got %b expected 0000", bus.stage_rst_n);
    end
    release_rst(4'b0000);
    wait_bit(0, e);
    vectors++;
    if (e !== 8) begin
      errors++; $display("FAIL mid_restart_edge: got edge %0d expected 8", e);
    end
    vectors++;
    if (bus.stage_rst_n !== 4'b0001) begin
      errors++; $display("FAIL mid_restart_mask: got %b expected 0001", bus.stage_rst_n);
    end
  endtask

`ifdef RST_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int e;
    // Ack arriving on the deadline edge beats the watchdog.
    release_rst(4'b0000);
    bring_up(2);
    wait_bit(2, e);
    repeat (31) tick();
    bus.stage_ack[2] = 1'b1;
    tick();
    vectors++;
    if (bus.seq_fault !== 1'b0) begin
      errors++; $display("FAIL to_ack_wins: got fault %b expected 0 at edge %0d", bus.seq_fault, edge_n);
    end
    wait_bit(3, e);
    vectors++;
    if (e !== 59) begin
      errors++; $display("FAIL to_ack_wins_edge: got edge %0d expected 59", e);
    end
    release_rst(4'b0000);
    bring_up(2);
    wait_bit(2, e);
    repeat (31) tick();
    vectors++;
    if (bus.seq_fault !== 1'b0 || bus.stage_rst_n !== 4'b0111) begin
      errors++; $display("FAIL to_pre: got fault %b rst %b expected 0 0111", bus.seq_fault, bus.stage_rst_n);
    end
    tick();
    vectors++;
    if (bus.seq_fault !== 1'b1 || bus.fault_stage !== 2'd2 || bus.stage_rst_n !== 4'b0000) begin
      errors++; $display("FAIL to_fault: got fault %b stage %0d rst %b expected 1 2 0000",
                         bus.seq_fault, bus.fault_stage, bus.stage_rst_n);
    end
    bus.stage_ack[2] = 1'b1;
    repeat (3) tick();
    vectors++;
    if (bus.seq_fault !== 1'b1 || bus.stage_rst_n !== 4'b0000) begin
      errors++; $display("FAIL to_held: got fault %b rst %b expected 1 0000", bus.seq_fault, bus.stage_rst_n);
    end
    bus.sw_reset_req = 1'b1;
    tick();
    bus.sw_reset_req = 1'b0;
    vectors++;
    if (bus.seq_fault !== 1'b0 || bus.fault_stage !== 2'd2) begin
      errors++; $display("FAIL to_warm: got fault %b stage %0d expected 0 2", bus.seq_fault, bus.fault_stage);
    end
  endtask
`else
  task automatic test_no_timeout();
    int e;
    release_rst(4'b0000);
    bring_up(2);
    wait_bit(2, e);
    repeat (100) tick();
    vectors++;
    if (bus.seq_fault !== 1'b0 || bus.fault_stage !== 2'd0 || bus.stage_rst_n !== 4'b0111) begin
      errors++; $display("FAIL nto_wait: got fault %b stage %0d rst %b expected 0 0 0111",
                         bus.seq_fault, bus.fault_stage, bus.stage_rst_n);
    end
    bus.stage_ack[2] = 1'b1;
    wait_bit(3, e);
    vectors++;
    if (e !== 128) begin
      errors++; $display("FAIL nto_resume_edge: got edge %0d expected 128", e);
    end
    tick();
    bus.stage_ack[3] = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.seq_done !== 1'b1) begin
      errors++; $display("FAIL nto_done: got %b expected 1 at edge %0d", bus.seq_done, edge_n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cold();
    test_warm();
    test_early_acks();
    test_mid_reset();
`ifdef RST_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
